work_dispatcher: RTL and testbench

Splits each 640-bit work unit from the host link across `NUM_CORES` hash cores, with each core assigned a disjoint slice of the 32-bit nonce space. Starts the cores in sequence, aborts them when superseding work arrives and detects exhaustion. Funnels core hits through a round-robin arbiter onto the single `new_result`/`result_data` pair. Sits between the serial work receiver and the core array, in place of the echo-only work handler.

---
 rtl/miner_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/work_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_work_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared miner types: header/nonce geometry and dispatcher states.
// No ports; imported by the dispatcher and its sub-modules.
package miner_pkg;

  localparam int HEADER_W  = 640;
  localparam int NONCE_W   = 32;
  localparam int NONCE_MSB = 639;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    ABORT
  } disp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; one-hot grant, pointer moves past each grant.
// Ports: clk, rst (sync, high), i_req[W], o_gnt[W].
module rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_req,
  output logic [W-1:0] o_gnt
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_any;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_j;

  // Scan from the pointer, wrapping at W (W need not be a power of two).
  always_comb begin
    o_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    w_sum = '0;
    w_j   = '0;
    for (int k = 0; k < W; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(W))
        w_sum = w_sum - (PW+1)'(W);
      w_j = w_sum[PW-1:0];
      if (!w_any && i_req[w_j]) begin
        w_any     = 1'b1;
        w_idx     = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_any)
      r_ptr <= (w_idx == PW'(W-1)) ? '0 : w_idx + PW'(1);
  end

endmodule

// File: rtl/work_dispatcher.sv
// Splits work units across hash cores by nonce slice, funnels hits out.
// Ports: clk/rst, new_work/work_data in; core_* to/from cores;
//   new_result/result_data, exhausted, result_overflow, idle out.
import miner_pkg::*;

module work_dispatcher #(
  parameter int NUM_CORES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            new_work,
  input  logic [HEADER_W-1:0]             work_data,
  output logic [HEADER_W-NONCE_W-1:0]     core_header,
  output logic [NONCE_W*NUM_CORES-1:0]    core_nonce,
  output logic [NUM_CORES-1:0]            core_start,
  output logic                            core_abort,
  input  logic [NUM_CORES-1:0]            core_busy,
  input  logic [NUM_CORES-1:0]            core_found,
  input  logic [NONCE_W*NUM_CORES-1:0]    core_found_nonce,
  output logic                            new_result,
  output logic [NONCE_W-1:0]              result_data,
  output logic                            exhausted,
  output logic                            result_overflow,
  output logic                            idle
);

  localparam int IW = $clog2(NUM_CORES);
  localparam logic [63:0] STRIDE =
    64'h1_0000_0000 / 64'(NUM_CORES);
  localparam logic [IW-1:0] LAST = IW'(NUM_CORES-1);

  disp_state_e r_state;
  logic [IW-1:0] r_idx;
  logic [1:0]    r_run_cnt;
  logic          r_done;

  logic [NUM_CORES-1:0] r_pend_v;
  logic [NONCE_W-1:0]   r_pend_n [NUM_CORES];

  logic                 w_active;
  logic                 w_clear;
  logic                 w_exh;
  logic                 w_any_gnt;
  logic [NUM_CORES-1:0] w_cap;
  logic [NUM_CORES-1:0] w_gnt;
  logic [NONCE_W-1:0]   w_gnt_nonce;
  logic [NONCE_W-1:0]   w_base;

  assign w_active  = (r_state == LOAD) ||
                     (r_state == RUN);
  // Pending hits die with the work they belong to.
  assign w_clear   = (w_active && new_work) ||
                     (r_state == ABORT);
  assign w_cap     = (w_active && !new_work) ?
                     core_found : '0;
  assign w_exh     = (core_busy == '0) && r_run_cnt[1];
  assign w_any_gnt = |w_gnt;
  assign w_base    = work_data[NONCE_MSB -: NONCE_W];

  rr_arbiter #(
    .W(NUM_CORES)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .i_req(r_pend_v),
    .o_gnt(w_gnt)
  );

  always_comb begin
    w_gnt_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (w_gnt[i])
        w_gnt_nonce = r_pend_n[i];
  end

  // A hit on a core whose slot is granted this cycle replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v <= '0;
      for (int i = 0; i < NUM_CORES; i++)
        r_pend_n[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_clear) begin
          r_pend_v[i] <= 1'b0;
        end else if (w_cap[i]) begin
          if (!r_pend_v[i] || w_gnt[i]) begin
            r_pend_v[i] <= 1'b1;
            r_pend_n[i] <= core_found_nonce[NONCE_W*i +: NONCE_W];
          end
        end else if (w_gnt[i]) begin
          r_pend_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_run_cnt       <= '0;
      r_done          <= 1'b0;
      core_header     <= '0;
      core_nonce      <= '0;
      core_start      <= '0;
      core_abort      <= 1'b0;
      new_result      <= 1'b0;
      result_data     <= '0;
      exhausted       <= 1'b0;
      result_overflow <= 1'b0;
      idle            <= 1'b1;
    end else begin
      core_start <= '0;
      core_abort <= 1'b0;
      exhausted  <= 1'b0;
      new_result <= w_any_gnt;
      if (w_any_gnt)
        result_data <= w_gnt_nonce;
      if (|(w_cap & r_pend_v & ~w_gnt))
        result_overflow <= 1'b1;
      if (new_work) begin
        core_header <= work_data[HEADER_W-NONCE_W-1:0];
        for (int i = 0; i < NUM_CORES; i++)
          core_nonce[NONCE_W*i +: NONCE_W] <=
            w_base + NONCE_W'(STRIDE * 64'(i));
        result_overflow <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          // Core 0 starts on the same edge the header lands.
          if (new_work) begin
            core_start <= NUM_CORES'(1);
            r_idx      <= IW'(1);
            r_state    <= LOAD;
            idle       <= 1'b0;
          end
        end
        LOAD: begin
          if (new_work) begin
            core_abort <= 1'b1;
            r_state    <= ABORT;
          end else begin
            core_start[r_idx] <= 1'b1;
            r_idx <= r_idx + IW'(1);
            if (r_idx == LAST) begin
              r_state   <= RUN;
              r_run_cnt <= '0;
              r_done    <= 1'b0;
            end
          end
        end
        RUN: begin
          if (new_work) begin
            core_abort <= 1'b1;
            r_state    <= ABORT;
          end else begin
            // Cores need two cycles after start to raise busy.
            if (!r_run_cnt[1])
              r_run_cnt <= r_run_cnt + 2'd1;
            if (w_exh && !r_done) begin
              exhausted <= 1'b1;
              r_done    <= 1'b1;
            end
            if (w_exh && r_pend_v == '0 &&
                core_found == '0) begin
              r_state <= IDLE;
              idle    <= 1'b1;
            end
          end
        end
        ABORT: begin
          core_start <= NUM_CORES'(1);
          r_idx      <= IW'(1);
          r_state    <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed + randomized bench for work_dispatcher.
// Reference: nonce slice arithmetic and cyclic hit order.
module tb_work_dispatcher;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            new_work;
  logic [639:0]    work_data;
  logic [607:0]    core_header;
  logic [32*N-1:0] core_nonce;
  logic [N-1:0]    core_start;
  logic            core_abort;
  logic [N-1:0]    core_busy;
  logic [N-1:0]    core_found;
  logic [32*N-1:0] core_found_nonce;
  logic            new_result;
  logic [31:0]     result_data;
  logic            exhausted;
  logic            result_overflow;
  logic            idle;

  always #5 clk = ~clk;

  work_dispatcher #(.NUM_CORES(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .new_work        (new_work),
    .work_data       (work_data),
    .core_header     (core_header),
    .core_nonce      (core_nonce),
    .core_start      (core_start),
    .core_abort      (core_abort),
    .core_busy       (core_busy),
    .core_found      (core_found),
    .core_found_nonce(core_found_nonce),
    .new_result      (new_result),
    .result_data     (result_data),
    .exhausted       (exhausted),
    .result_overflow (result_overflow),
    .idle            (idle)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_abort = 0;
  int n_exh = 0;
  int ptr = 0;
  logic [31:0] res_q[$];

  always @(negedge clk) begin
    if (new_result === 1'b1) res_q.push_back(result_data);
    if (core_abort === 1'b1) n_abort++;
    if (exhausted === 1'b1) n_exh++;
  end

  task automatic chk(input string tag, input logic [639:0] obs,
                     input logic [639:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slice(input logic [31:0] b,
                                        input int i);
    logic [63:0] t;
    t = {32'h0, b} + (64'h1_0000_0000 / 64'(N)) * 64'(i);
    return t[31:0];
  endfunction

  task automatic send(input logic [31:0] base,
                      output logic [607:0] hdr);
    for (int w = 0; w < 19; w++) hdr[32*w +: 32] = $urandom();
    work_data = {base, hdr};
    new_work = 1'b1;
    cyc();
    new_work = 1'b0;
  endtask

  task automatic chk_nonces(input string tag, input logic [31:0] b);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_nonce%0d", tag, i),
          640'(core_nonce[32*i +: 32]), 640'(slice(b, i)));
  endtask

  task automatic chk_starts(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_start%0d", tag, i),
          640'(core_start), 640'(1 << i));
      cyc();
    end
    chk({tag, "_start_end"}, 640'(core_start), 640'(0));
  endtask

  task automatic hit(input logic [N-1:0] m,
                     input logic [32*N-1:0] nn);
    core_found = m;
    core_found_nonce = nn;
    cyc();
    core_found = '0;
  endtask

  task automatic rand_nonces(output logic [32*N-1:0] nn);
    for (int i = 0; i < N; i++) nn[32*i +: 32] = $urandom();
  endtask

  // One burst drains in cyclic core order starting at the pointer.
  task automatic burst_check(input string tag, input logic [N-1:0] m,
                             input logic [32*N-1:0] nn);
    int cnt;
    int j;
    int last;
    cnt = 0;
    last = ptr;
    hit(m, nn);
    repeat (N + 2) cyc();
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (m[j]) begin
        chk($sformatf("%s_res%0d", tag, cnt),
            640'((cnt < res_q.size()) ? res_q[cnt] : 32'hx),
            640'(nn[32*j +: 32]));
        cnt++;
        last = j;
      end
    end
    chk({tag, "_cnt"}, 640'(res_q.size()), 640'(cnt));
    ptr = (last + 1) % N;
    res_q.delete();
  endtask

  logic [607:0]    h;
  logic [31:0]     b;
  logic [32*N-1:0] nn;
  logic [32*N-1:0] nb;
  logic [N-1:0]    m;

  initial begin
    rst = 1'b1;
    new_work = 1'b0;
    work_data = '0;
    core_busy = '0;
    core_found = '0;
    core_found_nonce = '0;
    repeat (3) cyc();
    chk("rst_idle", 640'(idle), 640'(1));
    chk("rst_start", 640'(core_start), 640'(0));
    chk("rst_abort", 640'(core_abort), 640'(0));
    chk("rst_result", 640'(new_result), 640'(0));
    chk("rst_data", 640'(result_data), 640'(0));
    chk("rst_exh", 640'(exhausted), 640'(0));
    chk("rst_ovf", 640'(result_overflow), 640'(0));
    chk("rst_nonce", 640'(core_nonce), 640'(0));
    chk("rst_hdr", 640'(core_header), 640'(0));
    rst = 1'b0;
    cyc();
    n_abort = 0;
    n_exh = 0;
    res_q.delete();

    // Wrapping slices
    core_busy = '1;
    send(32'hC000_0001, h);
    chk("wrap_hdr", 640'(core_header), 640'(h));
    chk_nonces("wrap", 32'hC000_0001);
    chk("wrap_n1_lit", 640'(core_nonce[63:32]), 640'(32'h0000_0001));
    chk("wrap_idle", 640'(idle), 640'(0));
    chk_starts("wrap");

    // Simultaneous hits on cores 1 and 3
    nn = {32'h33, 32'h0, 32'h11, 32'h0};
    hit(4'b1010, nn);
    chk("sim_early", 640'(new_result), 640'(0));
    cyc();
    chk("sim_r1", 640'(new_result), 640'(1));
    chk("sim_d1", 640'(result_data), 640'(32'h11));
    cyc();
    chk("sim_r2", 640'(new_result), 640'(1));
    chk("sim_d2", 640'(result_data), 640'(32'h33));
    cyc();
    chk("sim_r3", 640'(new_result), 640'(0));
    ptr = 0;
    res_q.delete();
    rand_nonces(nn);
    burst_check("sim01", 4'b0011, nn);

    // Overflow: core 2 hit twice while core 3 holds priority
    rand_nonces(nn);
    burst_check("ovf_pre", 4'b0100, nn);
    rand_nonces(nn);
    rand_nonces(nb);
    hit(4'b1100, nn);
    hit(4'b0101, nb);
    repeat (5) cyc();
    chk("ovf_flag", 640'(result_overflow), 640'(1));
    chk("ovf_cnt", 640'(res_q.size()), 640'(3));
    if (res_q.size() == 3) begin
      chk("ovf_r0", 640'(res_q[0]), 640'(nn[127:96]));
      chk("ovf_r1", 640'(res_q[1]), 640'(nb[31:0]));
      chk("ovf_r2", 640'(res_q[2]), 640'(nn[95:64]));
    end
    ptr = 3;
    cyc();
    chk("ovf_sticky", 640'(result_overflow), 640'(1));
    res_q.delete();

    // Abort during RUN with all four hits pending
    rand_nonces(nn);
    core_found = '1;
    core_found_nonce = nn;
    cyc();
    core_found = '0;
    b = $urandom();
    send(b, h);
    chk("abt_pulse", 640'(core_abort), 640'(1));
    chk("abt_ovf_clr", 640'(result_overflow), 640'(0));
    chk("abt_res", 640'(new_result), 640'(1));
    chk("abt_data", 640'(result_data), 640'(nn[32*ptr +: 32]));
    chk("abt_hdr", 640'(core_header), 640'(h));
    chk_nonces("abt", b);
    chk("abt_nostart", 640'(core_start), 640'(0));
    ptr = (ptr + 1) % N;
    cyc();
    chk("abt_once", 640'(core_abort), 640'(0));
    chk_starts("abt");
    repeat (4) cyc();
    chk("abt_res_cnt", 640'(res_q.size()), 640'(1));
    chk("abt_cnt", 640'(n_abort), 640'(1));
    res_q.delete();

    // Randomized hit bursts
    for (int r = 0; r < 12; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      rand_nonces(nn);
      burst_check($sformatf("rnd%0d", r), m, nn);
    end

    // Exhaustion after a long run
    core_busy = '0;
    cyc();
    chk("exh_pulse", 640'(exhausted), 640'(1));
    chk("exh_idle", 640'(idle), 640'(1));
    cyc();
    chk("exh_once", 640'(exhausted), 640'(0));
    repeat (5) cyc();
    chk("exh_cnt", 640'(n_exh), 640'(1));

    // Exhaustion waits two cycles after the last start
    b = $urandom();
    send(b, h);
    chk_nonces("bnd", b);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("bnd_exh_t%0d", k),
          640'(exhausted), 640'(k == 7));
      chk($sformatf("bnd_start_t%0d", k), 640'(core_start),
          640'((k <= N) ? (1 << (k - 1)) : 0));
      if (k < 7) cyc();
    end
    chk("bnd_idle", 640'(idle), 640'(1));

    // Reset during LOAD
    core_busy = '1;
    send($urandom(), h);
    cyc();
    rst = 1'b1;
    cyc();
    chk("mrst_idle", 640'(idle), 640'(1));
    chk("mrst_start", 640'(core_start), 640'(0));
    chk("mrst_abort", 640'(core_abort), 640'(0));
    chk("mrst_nonce", 640'(core_nonce), 640'(0));
    chk("mrst_hdr", 640'(core_header), 640'(0));
    chk("mrst_exh", 640'(exhausted), 640'(0));
    rst = 1'b0;
    repeat (3) cyc();
    chk("mrst_no_abort", 640'(n_abort), 640'(1));
    chk("mrst_stay_idle", 640'(idle), 640'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
